uart_value_printer: RTL and testbench



---
 rtl/uart_value_printer_pkg.sv | 35 +++
 rtl/uart_value_printer_div10.sv | 58 +++++
 rtl/uart_value_printer.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_value_printer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_value_printer_pkg.sv
// Shared types and constants for the UART decimal value printer.
// UART_VALUE_PRINTER_INDEX_EN adds the index-conversion state.
package uart_value_printer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CONV,
    EMIT,
    GAP
`ifdef UART_VALUE_PRINTER_INDEX_EN
    , IDX_CONV
`endif
  } state_t;

  typedef enum logic [2:0] {
    PH_IDX,
    PH_COLON,
    PH_SPACE,
    PH_MINUS,
    PH_DIG,
    PH_SEP
  } phase_t;

  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] SPACE = 8'h20;

  // ceil(width * log10(2)) in integer arithmetic
  function automatic int max_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/uart_value_printer_div10.sv
// Sequential restoring divide-by-10, one quotient bit per cycle.
// start_i loads the dividend; done_o pulses once quot_o/rem_o are valid.
module div10_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  output logic         done_o,
  output logic [W-1:0] quot_o,
  output logic [3:0]   rem_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  q_q;
  logic [3:0]    r_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          done_q;
  logic [4:0]    t;
  logic          ge;

  assign t  = {r_q, q_q[W-1]};
  assign ge = (t >= 5'd10);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        q_q   <= dividend_i;
        r_q   <= '0;
        cnt_q <= CW'(W - 1);
        run_q <= 1'b1;
      end else if (run_q) begin
        q_q   <= {q_q[W-2:0], ge};
        r_q   <= ge ? 4'(t - 5'd10) : t[3:0];
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = q_q;
  assign rem_o  = r_q;

endmodule

// File: rtl/uart_value_printer.sv
// Prints buffered signed values as decimal lines over a UART byte port.
// UART_VALUE_PRINTER_INDEX_EN prefixes each line with "<idx>: ".
module uart_value_printer
  import uart_value_printer_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter int         DEPTH   = 100,
  parameter logic [7:0] TRIGGER = 8'h68,
  parameter logic [7:0] SEP     = 8'h0A
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH+1)-1:0] print_count,
  input  logic [7:0]                 rx_data,
  input  logic                       new_rx_data,
  output logic [7:0]                 tx_data,
  output logic                       new_tx_data,
  input  logic                       tx_busy,
  output logic                       busy,
  output logic                       done
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int MAXD = max_digits(DATA_W);
  localparam int DCW  = $clog2(MAXD + 1);

  state_t            state_q, state_d;
  phase_t            ph_q, ph_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     n_q, n_d;
  logic              ld_q, ld_d;
  logic              neg_q, neg_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [DCW-1:0]    dcnt_q, dcnt_d;
  logic              last_q, last_d;
  logic [7:0]        tx_q, tx_d;
  logic              stb_q, stb_d;
  logic              done_q, done_d;
  logic [3:0]        dig_q [MAXD];
  logic              push_dig;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  logic              div_start;
  logic [DATA_W-1:0] div_in;
  logic              div_done;
  logic [DATA_W-1:0] div_quot;
  logic [3:0]        div_rem;

`ifdef UART_VALUE_PRINTER_INDEX_EN
  localparam int IMAXD = max_digits(AW);
  localparam int ICW   = $clog2(IMAXD + 1);
  logic [ICW-1:0] icnt_q, icnt_d;
  logic [3:0]     istk_q [IMAXD];
  logic           push_idx;
`endif

  div10_seq #(.W(DATA_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (div_in),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) mem_q[wr_addr] <= wr_data;
    rd_q <= mem_q[idx_q];
    if (push_dig) dig_q[dcnt_q] <= div_rem;
`ifdef UART_VALUE_PRINTER_INDEX_EN
    if (push_idx) istk_q[icnt_q] <= div_rem;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= PH_SEP;
      idx_q   <= '0;
      n_q     <= '0;
      ld_q    <= 1'b0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      dcnt_q  <= '0;
      last_q  <= 1'b0;
      tx_q    <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_VALUE_PRINTER_INDEX_EN
      icnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      ld_q    <= ld_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      dcnt_q  <= dcnt_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
`ifdef UART_VALUE_PRINTER_INDEX_EN
      icnt_q  <= icnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    idx_d     = idx_q;
    n_d       = n_q;
    ld_d      = ld_q;
    neg_d     = neg_q;
    mag_d     = mag_q;
    dcnt_d    = dcnt_q;
    last_d    = last_q;
    tx_d      = tx_q;
    stb_d     = 1'b0;
    done_d    = 1'b0;
    push_dig  = 1'b0;
    div_start = 1'b0;
    div_in    = mag_q;
`ifdef UART_VALUE_PRINTER_INDEX_EN
    icnt_d    = icnt_q;
    push_idx  = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (new_rx_data && rx_data == TRIGGER) begin
        if (print_count == '0) begin
          done_d = 1'b1;
        end else begin
          n_d     = (32'(print_count) > DEPTH) ? CW'(DEPTH) : print_count;
          idx_d   = '0;
          ld_d    = 1'b0;
          state_d = LOAD;
        end
      end
      // first cycle issues the read, second captures it
      LOAD: begin
        ld_d = 1'b1;
        if (ld_q) begin
          ld_d      = 1'b0;
          neg_d     = rd_q[DATA_W-1];
          mag_d     = rd_q[DATA_W-1] ? -rd_q : rd_q;
          dcnt_d    = '0;
          div_start = 1'b1;
`ifdef UART_VALUE_PRINTER_INDEX_EN
          icnt_d    = '0;
          div_in    = DATA_W'(idx_q);
          state_d   = IDX_CONV;
`else
          div_in    = mag_d;
          state_d   = CONV;
`endif
        end
      end
`ifdef UART_VALUE_PRINTER_INDEX_EN
      IDX_CONV: if (div_done) begin
        push_idx  = 1'b1;
        icnt_d    = icnt_q + 1'b1;
        div_start = 1'b1;
        if (div_quot == '0) begin
          div_in  = mag_q;
          state_d = CONV;
        end else begin
          div_in  = div_quot;
        end
      end
`endif
      CONV: if (div_done) begin
        push_dig = 1'b1;
        dcnt_d   = dcnt_q + 1'b1;
        if (div_quot == '0) begin
          state_d = EMIT;
`ifdef UART_VALUE_PRINTER_INDEX_EN
          ph_d    = PH_IDX;
`else
          ph_d    = neg_q ? PH_MINUS : PH_DIG;
`endif
        end else begin
          div_start = 1'b1;
          div_in    = div_quot;
        end
      end
      EMIT: if (!tx_busy) begin
        stb_d   = 1'b1;
        state_d = GAP;
        unique case (ph_q)
`ifdef UART_VALUE_PRINTER_INDEX_EN
          PH_IDX: begin
            tx_d   = ZERO + {4'b0, istk_q[icnt_q - 1'b1]};
            icnt_d = icnt_q - 1'b1;
            if (icnt_q == ICW'(1)) ph_d = PH_COLON;
          end
          PH_COLON: begin
            tx_d = COLON;
            ph_d = PH_SPACE;
          end
          PH_SPACE: begin
            tx_d = SPACE;
            ph_d = neg_q ? PH_MINUS : PH_DIG;
          end
`endif
          PH_MINUS: begin
            tx_d = MINUS;
            ph_d = PH_DIG;
          end
          PH_DIG: begin
            tx_d   = ZERO + {4'b0, dig_q[dcnt_q - 1'b1]};
            dcnt_d = dcnt_q - 1'b1;
            if (dcnt_q == DCW'(1)) ph_d = PH_SEP;
          end
          default: begin
            tx_d   = SEP;
            last_d = 1'b1;
          end
        endcase
      end
      GAP: if (last_q) begin
        last_d = 1'b0;
        if (CW'(idx_q) == n_q - 1'b1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end else begin
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data     = tx_q;
  assign new_tx_data = stb_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_uart_value_printer.sv
// Self-checking bench for uart_value_printer: table vectors, random values
// against a buffer model, and hand-written trigger/reset sequences.
module tb_uart_value_printer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [6:0]  print_count = '0;
  logic [7:0]  rx_data = '0;
  logic        new_rx_data = 1'b0;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [7:0]  rxq [$];
  logic [31:0] mem_m [100];
  logic prev_stb = 1'b0;
  bit   busy_rand = 1'b0;

  typedef struct {
    logic [31:0] val;
    string       exp;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  uart_value_printer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .print_count (print_count),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .done        (done)
  );

  always @(negedge clk) begin
    if (new_tx_data === 1'b1) begin
      rxq.push_back(tx_data);
      tests++;
      if (prev_stb === 1'b1) begin
        fails++;
        $display("FAIL gap: strobe in consecutive cycles, got 1 want 0");
      end
    end
    prev_stb = new_tx_data;
    if (done === 1'b1) done_cnt++;
  end

  always @(negedge clk) begin
    if (busy_rand) tx_busy = ($urandom_range(0, 2) == 0);
    else tx_busy = 1'b0;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = 7'(a);
    wr_data = d;
    mem_m[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic string pfx(input int i);
`ifdef UART_VALUE_PRINTER_INDEX_EN
    return $sformatf("%0d: ", i);
`else
    return "";
`endif
  endfunction

  function automatic string fmt(input int i, input logic [31:0] v);
    return {pfx(i), $sformatf("%0d", $signed(v))};
  endfunction

  task automatic check_lines(input string exp[$]);
    string lines [$];
    string cur;
    cur = "";
    foreach (rxq[i]) begin
      if (rxq[i] == 8'h0A) begin
        lines.push_back(cur);
        cur = "";
      end else begin
        cur = $sformatf("%s%c", cur, rxq[i]);
      end
    end
    if (cur.len() != 0) lines.push_back(cur);
    check("line_count", lines.size(), exp.size());
    for (int i = 0; i < exp.size() && i < lines.size(); i++) begin
      tests++;
      if (lines[i] != exp[i]) begin
        fails++;
        $display("FAIL line%0d: got \"%s\" want \"%s\"", i, lines[i], exp[i]);
      end
    end
  endtask

  task automatic finish_run(input int d0, input int budget,
                            input string exp[$]);
    int t;
    t = 0;
    while (done_cnt == d0 && t < budget) begin
      tick();
      t++;
    end
    check("run_timeout", (t >= budget), 0);
    tick(4);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after", busy, 0);
    check_lines(exp);
  endtask

  task automatic model_run(input int cnt);
    string exp [$];
    int n;
    int d0;
    n = (cnt > 100) ? 100 : cnt;
    for (int i = 0; i < n; i++) exp.push_back(fmt(i, mem_m[i]));
    rxq.delete();
    d0 = done_cnt;
    print_count = 7'(cnt);
    send(8'h68);
    finish_run(d0, n * 1500 + 50, exp);
  endtask

  initial begin
    string exp [$];
    int d0;
    int t;
    logic [31:0] v;

    tbl[0] = '{32'd123, "123"};
    tbl[1] = '{32'hFFFF_FFFB, "-5"};
    tbl[2] = '{32'd0, "0"};
    tbl[3] = '{32'h8000_0000, "-2147483648"};
    tbl[4] = '{32'h7FFF_FFFF, "2147483647"};
    tbl[5] = '{32'd10, "10"};
    tbl[6] = '{32'hFFFF_FFFF, "-1"};
    tbl[7] = '{32'd1000000000, "1000000000"};
    tbl[8] = '{32'd9, "9"};

    tick(3);
    check("rst_tx_data", tx_data, 0);
    check("rst_new_tx", new_tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick(2);

    // table vectors with random tx_busy back-pressure
    busy_rand = 1'b1;
    foreach (tbl[i]) wr(i, tbl[i].val);
    exp.delete();
    foreach (tbl[i]) exp.push_back({pfx(i), tbl[i].exp});
    rxq.delete();
    d0 = done_cnt;
    print_count = 7'd9;
    send(8'h68);
    finish_run(d0, 9 * 1500 + 50, exp);

    // random contents, count above DEPTH clamps to 100 lines
    for (int i = 0; i < 100; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      wr(i, v);
    end
    model_run(127);

    // zero count: no bytes, one done pulse
    model_run(0);

    // non-trigger byte in IDLE is ignored
    rxq.delete();
    send(8'h78);
    tick(10);
    check("x_idle_busy", busy, 0);
    check("x_idle_bytes", rxq.size(), 0);

    // bytes arriving mid-run are ignored
    wr(0, 32'd77);
    wr(1, 32'hFFFF_FFF8);
    exp.delete();
    exp.push_back(fmt(0, mem_m[0]));
    exp.push_back(fmt(1, mem_m[1]));
    rxq.delete();
    d0 = done_cnt;
    print_count = 7'd2;
    send(8'h68);
    tick(5);
    send(8'h78);
    tick(3);
    send(8'h68);
    finish_run(d0, 3000, exp);
    tick(200);
    check("retrigger_done", done_cnt - d0, 1);
    check("retrigger_bytes", rxq.size(), exp[0].len() + exp[1].len() + 2);

    // reset during the third byte of a line
    wr(0, 32'd12345);
    wr(1, 32'hFFFF_FFFD);
    rxq.delete();
    print_count = 7'd2;
    send(8'h68);
    t = 0;
    while (rxq.size() < 3 && t < 5000) begin
      tick();
      t++;
    end
    check("rst_reach", (t >= 5000), 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rst_quiet", {new_tx_data, busy}, 0);
      tick();
    end
    rst = 1'b0;
    tick(20);
    check("rst_bytes", rxq.size(), 3);
    check("rst_busy_after", busy, 0);
    model_run(2);

`ifdef UART_VALUE_PRINTER_INDEX_EN
    wr(10, 32'hFFFF_FFD6);
    model_run(11);
    tests++;
    if (rxq.size() < 8 || rxq[rxq.size() - 8] != 8'h31) begin
      fails++;
      $display("FAIL idx_line10: line 11 does not start with \"10: -42\"");
    end
`endif

    busy_rand = 1'b0;
    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
